// File: rtl/controlador_busca_caminho.sv
// Search control for the pathfinding datapath: request handshake, iniciar/expandir sequencing,
// predecessor walk and path streaming. Define CONTROLADOR_BUSCA_ORDEM_DIRETA_EN to emit fonte first.
module controlador_busca_caminho #(
   parameter int ADDR_WIDTH = 6,
   parameter int MAX_CICLOS = 1024,
   parameter int CNT_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic [ADDR_WIDTH-1:0] req_fonte_in,
   input  logic [ADDR_WIDTH-1:0] req_destino_in,
   output logic [ADDR_WIDTH-1:0] fonte_out,
   output logic [ADDR_WIDTH-1:0] destino_out,
   output logic                  iniciar_out,
   output logic                  expandir_out,
   input  logic                  tem_ativo_in,
   input  logic                  destino_estabelecido_in,
   output logic                  anterior_rd_en_out,
   output logic [ADDR_WIDTH-1:0] anterior_rd_addr_out,
   input  logic [ADDR_WIDTH-1:0] anterior_rd_data_in,
   output logic                  caminho_valid_out,
   input  logic                  caminho_ready_in,
   output logic [ADDR_WIDTH-1:0] caminho_addr_out,
   output logic                  caminho_last_out,
   output logic                  caminho_pronto_out,
   output logic                  sem_caminho_out,
   output logic                  ocupado_out
);

   typedef enum logic [2:0] {
      AGUARDANDO, INICIAR, EXPANDIR, LER, ENVIAR, FALHA, EMPILHAR
   } estado_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LIMITE = CNT_WIDTH'(MAX_CICLOS - 1);

   estado_t estado_q, estado_d;

   logic [ADDR_WIDTH-1:0] fonte_q, destino_q, atual_q;
   logic [CNT_WIDTH-1:0]  exp_cnt_q;
   logic                  pronto_q;
   logic                  aceita_req, aceita_beat, ultimo, pede_leitura;
   logic [ADDR_WIDTH-1:0] saida_addr;

`ifdef CONTROLADOR_BUSCA_ORDEM_DIRETA_EN
   // LIFO reverses the predecessor walk so the stream starts at fonte
   logic [ADDR_WIDTH-1:0] lifo [2**ADDR_WIDTH];
   logic [ADDR_WIDTH:0]   sp_q, sp_m1;
   logic                  cheio;

   assign sp_m1        = sp_q - 1'b1;
   assign cheio        = sp_q[ADDR_WIDTH];
   assign ultimo       = (sp_q == (ADDR_WIDTH+1)'(1));
   assign saida_addr   = lifo[sp_m1[ADDR_WIDTH-1:0]];
   assign pede_leitura = (estado_q == EMPILHAR) && !cheio && (atual_q != fonte_q);
`else
   logic [ADDR_WIDTH-1:0] len_q;

   assign ultimo       = (atual_q == fonte_q);
   assign saida_addr   = atual_q;
   assign pede_leitura = aceita_beat && !ultimo;
`endif

   assign aceita_req  = req_valid_in && req_ready_out;
   assign aceita_beat = (estado_q == ENVIAR) && caminho_ready_in;
   assign fonte_out   = fonte_q;
   assign destino_out = destino_q;

   // State register and control flags
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q  <= AGUARDANDO;
         pronto_q  <= 1'b0;
         fonte_q   <= '0;
         destino_q <= '0;
      end else begin
         estado_q <= estado_d;
         pronto_q <= aceita_beat && ultimo;
         if (aceita_req) begin
            fonte_q   <= req_fonte_in;
            destino_q <= req_destino_in;
         end
      end
   end

   // Walk pointer and counters; always restarted on accept, so no reset needed
   always_ff @(posedge clk) begin
      if (aceita_req) begin
         atual_q   <= req_destino_in;
         exp_cnt_q <= '0;
      end
      if (estado_q == EXPANDIR) begin
         exp_cnt_q <= exp_cnt_q + 1'b1;
         if (destino_estabelecido_in)
            atual_q <= destino_q;
      end
      if (estado_q == LER)
         atual_q <= anterior_rd_data_in;
`ifdef CONTROLADOR_BUSCA_ORDEM_DIRETA_EN
      if (aceita_req) begin
         lifo[0] <= req_fonte_in;
         sp_q    <= (req_fonte_in == req_destino_in) ? (ADDR_WIDTH+1)'(1) : '0;
      end
      if (estado_q == EMPILHAR && !cheio) begin
         lifo[sp_q[ADDR_WIDTH-1:0]] <= atual_q;
         sp_q                       <= sp_q + 1'b1;
      end
      if (aceita_beat)
         sp_q <= sp_m1;
`else
      if (aceita_req)
         len_q <= '0;
      if (estado_q == LER)
         len_q <= len_q + 1'b1;
`endif
   end

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         AGUARDANDO:
            if (aceita_req)
               estado_d = (req_fonte_in == req_destino_in) ? ENVIAR : INICIAR;
         INICIAR:
            estado_d = EXPANDIR;
         EXPANDIR: begin
            // tem_ativo_in lags the seed by a cycle, so the first expansion cycle ignores it
            if (destino_estabelecido_in)
`ifdef CONTROLADOR_BUSCA_ORDEM_DIRETA_EN
               estado_d = EMPILHAR;
`else
               estado_d = ENVIAR;
`endif
            else if (!tem_ativo_in && exp_cnt_q != '0)
               estado_d = FALHA;
            else if (exp_cnt_q == CNT_LIMITE)
               estado_d = FALHA;
         end
         ENVIAR:
            if (aceita_beat) begin
               if (ultimo)
                  estado_d = AGUARDANDO;
               else
`ifdef CONTROLADOR_BUSCA_ORDEM_DIRETA_EN
                  estado_d = ENVIAR;
`else
                  estado_d = LER;
`endif
            end
`ifdef CONTROLADOR_BUSCA_ORDEM_DIRETA_EN
         EMPILHAR:
            if (cheio)
               estado_d = FALHA;
            else if (atual_q == fonte_q)
               estado_d = ENVIAR;
            else
               estado_d = LER;
         LER:
            estado_d = EMPILHAR;
`else
         LER:
            // A walk as long as the address space can only be a predecessor cycle
            estado_d = (&len_q) ? FALHA : ENVIAR;
`endif
         FALHA:
            estado_d = AGUARDANDO;
         default:
            estado_d = AGUARDANDO;
      endcase
   end

   always_comb begin
      req_ready_out        = 1'b0;
      ocupado_out          = 1'b0;
      iniciar_out          = 1'b0;
      expandir_out         = 1'b0;
      anterior_rd_en_out   = 1'b0;
      anterior_rd_addr_out = '0;
      caminho_valid_out    = 1'b0;
      caminho_addr_out     = '0;
      caminho_last_out     = 1'b0;
      caminho_pronto_out   = 1'b0;
      sem_caminho_out      = 1'b0;
      if (!rst) begin
         req_ready_out      = (estado_q == AGUARDANDO) && !pronto_q;
         ocupado_out        = (estado_q != AGUARDANDO) || pronto_q;
         iniciar_out        = (estado_q == INICIAR);
         expandir_out       = (estado_q == EXPANDIR);
         anterior_rd_en_out = pede_leitura;
         if (pede_leitura)
            anterior_rd_addr_out = atual_q;
         if (estado_q == ENVIAR) begin
            caminho_valid_out = 1'b1;
            caminho_addr_out  = saida_addr;
            caminho_last_out  = ultimo;
         end
         caminho_pronto_out = pronto_q;
         sem_caminho_out    = (estado_q == FALHA);
      end
   end

endmodule

// File: tb/tb_controlador_busca_caminho.sv
// Directed bench for controlador_busca_caminho (default build, path streamed destino first).
module tb_controlador_busca_caminho;

   localparam int AW   = 6;
   localparam int MAXC = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid_in = 1'b0;
   logic          req_ready_out;
   logic [AW-1:0] req_fonte_in = '0, req_destino_in = '0;
   logic [AW-1:0] fonte_out, destino_out;
   logic          iniciar_out, expandir_out;
   logic          tem_ativo_in = 1'b1;
   logic          destino_estabelecido_in = 1'b0;
   logic          anterior_rd_en_out;
   logic [AW-1:0] anterior_rd_addr_out;
   logic [AW-1:0] anterior_rd_data_in = '0;
   logic          caminho_valid_out;
   logic          caminho_ready_in = 1'b0;
   logic [AW-1:0] caminho_addr_out;
   logic          caminho_last_out, caminho_pronto_out, sem_caminho_out, ocupado_out;

   logic [AW-1:0] pred [2**AW];

   int n_tests = 0;
   int n_fail  = 0;

   controlador_busca_caminho #(.ADDR_WIDTH(AW), .MAX_CICLOS(MAXC), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_fonte_in(req_fonte_in), .req_destino_in(req_destino_in),
      .fonte_out(fonte_out), .destino_out(destino_out),
      .iniciar_out(iniciar_out), .expandir_out(expandir_out),
      .tem_ativo_in(tem_ativo_in), .destino_estabelecido_in(destino_estabelecido_in),
      .anterior_rd_en_out(anterior_rd_en_out), .anterior_rd_addr_out(anterior_rd_addr_out),
      .anterior_rd_data_in(anterior_rd_data_in),
      .caminho_valid_out(caminho_valid_out), .caminho_ready_in(caminho_ready_in),
      .caminho_addr_out(caminho_addr_out), .caminho_last_out(caminho_last_out),
      .caminho_pronto_out(caminho_pronto_out), .sem_caminho_out(sem_caminho_out),
      .ocupado_out(ocupado_out)
   );

   always #5 clk = ~clk;

   // Predecessor memory: one-cycle read latency
   always @(posedge clk)
      if (anterior_rd_en_out)
         anterior_rd_data_in <= pred[anterior_rd_addr_out];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic aceitar(input logic [AW-1:0] f, input logic [AW-1:0] d);
      req_valid_in   = 1'b1;
      req_fonte_in   = f;
      req_destino_in = d;
      #1;
      chk("req_ready_antes_aceite", req_ready_out, 1);
      step();
      req_valid_in = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] got [8];
      logic          got_last [8];
      logic [AW-1:0] prev_addr;
      logic          prev_last, hold, done, seen;
      int            n, k, reads, beats, lasts, prontos;

      for (int i = 0; i < 2**AW; i++) pred[i] = '0;
      pred[9] = 6'd4; pred[4] = 6'd1; pred[1] = 6'd0;

      // Reset with a pending request
      req_valid_in = 1'b1; req_fonte_in = 6'd3; req_destino_in = 6'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_req_ready", req_ready_out, 0);
         chk("rst_ocupado", ocupado_out, 0);
         chk("rst_valid", caminho_valid_out, 0);
         chk("rst_iniciar", iniciar_out, 0);
         chk("rst_sem_caminho", sem_caminho_out, 0);
      end
      rst = 1'b0; req_valid_in = 1'b0;
      #1;
      chk("pos_rst_req_ready", req_ready_out, 1);
      chk("pos_rst_fonte", fonte_out, 0);
      chk("pos_rst_destino", destino_out, 0);
      step();

      // fonte == destino: single beat, no search
      aceitar(6'd5, 6'd5);
      caminho_ready_in = 1'b0;
      #1;
      chk("igual_iniciar", iniciar_out, 0);
      chk("igual_valid", caminho_valid_out, 1);
      chk("igual_addr", caminho_addr_out, 5);
      chk("igual_last", caminho_last_out, 1);
      chk("igual_fonte_out", fonte_out, 5);
      chk("igual_ocupado", ocupado_out, 1);
      chk("igual_req_ready", req_ready_out, 0);
      caminho_ready_in = 1'b1;
      step();
      chk("igual_pronto", caminho_pronto_out, 1);
      chk("igual_valid_apos", caminho_valid_out, 0);
      chk("igual_ready_no_pronto", req_ready_out, 0);
      caminho_ready_in = 1'b0;
      step();
      chk("igual_pronto_unico", caminho_pronto_out, 0);
      chk("igual_ready_volta", req_ready_out, 1);

      // Path 9 -> 4 -> 1 -> 0 with random backpressure
      aceitar(6'd0, 6'd9);
      chk("path_iniciar", iniciar_out, 1);
      chk("path_expandir_cedo", expandir_out, 0);
      step();
      chk("path_expandir", expandir_out, 1);
      chk("path_iniciar_pulso", iniciar_out, 0);
      for (int i = 0; i < 9; i++) step();
      destino_estabelecido_in = 1'b1;
      step();
      destino_estabelecido_in = 1'b0;
      #1;
      chk("path_valid_e_mais_1", caminho_valid_out, 1);
      chk("path_primeiro_addr", caminho_addr_out, 9);
      n = 0; done = 1'b0; hold = 1'b0; prev_addr = '0; prev_last = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         caminho_ready_in = ($urandom_range(0, 1) == 1);
         #1;
         if (hold) begin
            chk("estavel_valid", caminho_valid_out, 1);
            chk("estavel_addr", caminho_addr_out, prev_addr);
            chk("estavel_last", caminho_last_out, prev_last);
         end
         hold = 1'b0;
         if (caminho_valid_out) begin
            if (caminho_ready_in) begin
               if (n < 8) begin
                  got[n]      = caminho_addr_out;
                  got_last[n] = caminho_last_out;
               end
               n++;
               if (caminho_last_out) done = 1'b1;
            end else begin
               hold      = 1'b1;
               prev_addr = caminho_addr_out;
               prev_last = caminho_last_out;
            end
         end
         step();
      end
      chk("path_terminou", done, 1);
      chk("path_pronto", caminho_pronto_out, 1);
      chk("path_n_beats", n, 4);
      if (n == 4) begin
         chk("path_beat0", got[0], 9);
         chk("path_beat1", got[1], 4);
         chk("path_beat2", got[2], 1);
         chk("path_beat3", got[3], 0);
         for (int b = 0; b < 4; b++) chk("path_last", got_last[b], (b == 3) ? 1 : 0);
      end
      caminho_ready_in = 1'b0;
      step();
      chk("path_ready_volta", req_ready_out, 1);

      // Empty frontier: ignored in the first cycle, fails on the 3rd
      aceitar(6'd0, 6'd9);
      step();
      tem_ativo_in = 1'b0;
      #1;
      step();
      chk("vazio_ignora_primeiro", expandir_out, 1);
      chk("vazio_sem_cedo", sem_caminho_out, 0);
      tem_ativo_in = 1'b1;
      step();
      tem_ativo_in = 1'b0;
      step();
      chk("vazio_sem_caminho", sem_caminho_out, 1);
      chk("vazio_valid", caminho_valid_out, 0);
      chk("vazio_pronto_exclusivo", caminho_pronto_out, 0);
      tem_ativo_in = 1'b1;
      step();
      chk("vazio_sem_unico", sem_caminho_out, 0);
      chk("vazio_ready_volta", req_ready_out, 1);

      // Cycle budget timeout
      aceitar(6'd0, 6'd9);
      step();
      chk("timeout_expandir", expandir_out, 1);
      k = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         k++;
         if (sem_caminho_out) seen = 1'b1;
      end
      chk("timeout_visto", seen, 1);
      chk("timeout_ciclos", k, MAXC);
      step();
      chk("timeout_ready_volta", req_ready_out, 1);

      // Predecessor loop 9 -> 4 -> 9
      pred[4] = 6'd9;
      aceitar(6'd0, 6'd9);
      step();
      destino_estabelecido_in = 1'b1;
      step();
      destino_estabelecido_in = 1'b0;
      caminho_ready_in = 1'b1;
      reads = 0; beats = 0; lasts = 0; prontos = 0; seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         #1;
         if (anterior_rd_en_out) reads++;
         if (caminho_valid_out && caminho_ready_in) beats++;
         if (caminho_last_out) lasts++;
         if (caminho_pronto_out) prontos++;
         if (sem_caminho_out) seen = 1'b1;
         else step();
      end
      chk("laco_sem_caminho", seen, 1);
      chk("laco_leituras", reads, 64);
      chk("laco_beats", beats, 64);
      chk("laco_sem_last", lasts, 0);
      chk("laco_sem_pronto", prontos, 0);
      caminho_ready_in = 1'b0;
      step();
      chk("laco_ready_volta", req_ready_out, 1);
      pred[4] = 6'd1;

      // Reset while a beat is stalled
      aceitar(6'd0, 6'd9);
      step();
      destino_estabelecido_in = 1'b1;
      step();
      destino_estabelecido_in = 1'b0;
      #1;
      chk("rstmeio_valid", caminho_valid_out, 1);
      rst = 1'b1;
      #1;
      chk("rstmeio_valid_zero", caminho_valid_out, 0);
      step();
      rst = 1'b0;
      #1;
      chk("rstmeio_ready", req_ready_out, 1);
      chk("rstmeio_ocupado", ocupado_out, 0);
      chk("rstmeio_pronto", caminho_pronto_out, 0);
      chk("rstmeio_sem", sem_caminho_out, 0);
      step();
      chk("rstmeio_pronto_depois", caminho_pronto_out, 0);
      chk("rstmeio_sem_depois", sem_caminho_out, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
